// File: rtl/sync_filter_shift_reg_if.sv
// Signal bundle for sync_filter_shift_reg: asynchronous input bits in,
// synchronized, filtered, edge and event-count status out.
interface sync_filter_shift_reg_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] io_d;
    logic             io_clr_count;
    logic [WIDTH-1:0] io_q;
    logic [WIDTH-1:0] io_q_stable;
    logic [WIDTH-1:0] io_rise;
    logic [WIDTH-1:0] io_fall;
    logic [CNT_W-1:0] io_evt_count;

    modport master (
        output io_d, io_clr_count,
        input  io_q, io_q_stable, io_rise, io_fall, io_evt_count
    );

    modport slave (
        input  io_d, io_clr_count,
        output io_q, io_q_stable, io_rise, io_fall, io_evt_count
    );
endinterface

// File: rtl/sync_filter_shift_reg.sv
// Multi-bit synchronizer: per-bit flop chain, stability filter and edge
// pulses, plus a saturating count of cycles carrying any edge.
module sync_filter_lane #(
    parameter int   DEPTH    = 3,
    parameter int   FILTER   = 4,
    parameter logic INIT_BIT = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic i_d,
    output logic o_q,
    output logic o_stable,
    output logic o_rise,
    output logic o_fall
);
    logic [DEPTH-1:0] r_chain;
    logic             r_hist;
    logic             w_stable;

    // Pure flop chain: nothing may sit between stages.
    always_ff @(posedge clock) begin
        if (!reset) r_chain <= {DEPTH{INIT_BIT}};
        else        r_chain <= {r_chain[DEPTH-2:0], i_d};
    end

    assign o_q = r_chain[DEPTH-1];

    generate
        if (FILTER == 0) begin : g_bypass
            assign w_stable = o_q;
        end else begin : g_filter
            localparam int            CW   = $clog2(FILTER + 1);
            localparam logic [CW-1:0] LAST = CW'(FILTER - 1);
            logic [CW-1:0] r_cnt;
            logic          r_stable;

            // Any return to the stable value restarts the run length.
            always_ff @(posedge clock) begin
                if (!reset) begin
                    r_cnt    <= '0;
                    r_stable <= INIT_BIT;
                end else if (o_q == r_stable) begin
                    r_cnt    <= '0;
                end else if (r_cnt == LAST) begin
                    r_stable <= o_q;
                    r_cnt    <= '0;
                end else begin
                    r_cnt    <= r_cnt + CW'(1);
                end
            end

            assign w_stable = r_stable;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!reset) r_hist <= INIT_BIT;
        else        r_hist <= w_stable;
    end

    assign o_stable = w_stable;
    assign o_rise   = w_stable & ~r_hist;
    assign o_fall   = ~w_stable & r_hist;
endmodule

module sync_filter_shift_reg #(
    parameter int               WIDTH  = 1,
    parameter int               DEPTH  = 3,
    parameter logic [WIDTH-1:0] INIT   = '0,
    parameter int               FILTER = 4,
    parameter int               CNT_W  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    sync_filter_shift_reg_if.slave bus
);
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic             w_event;
    logic [CNT_W-1:0] r_count;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
            sync_filter_lane #(
                .DEPTH    (DEPTH),
                .FILTER   (FILTER),
                .INIT_BIT (INIT[gi])
            ) u_lane (
                .clock    (clock),
                .reset    (reset),
                .i_d      (bus.io_d[gi]),
                .o_q      (w_q[gi]),
                .o_stable (w_stable[gi]),
                .o_rise   (w_rise[gi]),
                .o_fall   (w_fall[gi])
            );
        end
    endgenerate

    // Several bits toggling in one cycle count as a single event.
    assign w_event = |(w_rise | w_fall);

    always_ff @(posedge clock) begin
        if (!reset)                     r_count <= '0;
        else if (bus.io_clr_count)      r_count <= '0;
        else if (w_event && r_count != '1) r_count <= r_count + CNT_W'(1);
    end

    assign bus.io_q         = w_q;
    assign bus.io_q_stable  = w_stable;
    assign bus.io_rise      = w_rise;
    assign bus.io_fall      = w_fall;
    assign bus.io_evt_count = r_count;
endmodule

// File: tb/tb_sync_filter_shift_reg.sv
// Directed bench: four instances (default, INIT=11, CNT_W=2, FILTER=0)
// exercised in sequence with hand-derived expectations.
module tb_sync_filter_shift_reg;
    logic clock = 1'b0;
    logic rst_a, rst_b, rst_c, rst_d;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clock = ~clock;

    sync_filter_shift_reg_if #(.WIDTH(2), .CNT_W(8)) ifc_a ();
    sync_filter_shift_reg_if #(.WIDTH(2), .CNT_W(8)) ifc_b ();
    sync_filter_shift_reg_if #(.WIDTH(2), .CNT_W(2)) ifc_c ();
    sync_filter_shift_reg_if #(.WIDTH(2), .CNT_W(8)) ifc_d ();

    sync_filter_shift_reg #(.WIDTH(2), .DEPTH(3), .INIT(2'b00), .FILTER(4), .CNT_W(8))
        u_a (.clock(clock), .reset(rst_a), .bus(ifc_a));
    sync_filter_shift_reg #(.WIDTH(2), .DEPTH(3), .INIT(2'b11), .FILTER(4), .CNT_W(8))
        u_b (.clock(clock), .reset(rst_b), .bus(ifc_b));
    sync_filter_shift_reg #(.WIDTH(2), .DEPTH(3), .INIT(2'b00), .FILTER(4), .CNT_W(2))
        u_c (.clock(clock), .reset(rst_c), .bus(ifc_c));
    sync_filter_shift_reg #(.WIDTH(2), .DEPTH(3), .INIT(2'b00), .FILTER(0), .CNT_W(8))
        u_d (.clock(clock), .reset(rst_d), .bus(ifc_d));

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int         qhi, shi, nr, nf, t_qfall, t_sfall;
    logic [1:0] prevq, v, e_r, e_f;
    int         cnt_m;
    logic [1:0] ap[$];

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
        ifc_a.io_d = 2'b00; ifc_a.io_clr_count = 1'b0;
        ifc_b.io_d = 2'b11; ifc_b.io_clr_count = 1'b0;
        ifc_c.io_d = 2'b00; ifc_c.io_clr_count = 1'b0;
        ifc_d.io_d = 2'b00; ifc_d.io_clr_count = 1'b0;
        tick();

        // INIT=11 held through reset: outputs already 11, never a pulse
        chk("b_rst_q", ifc_b.io_q, 2'b11);
        chk("b_rst_stable", ifc_b.io_q_stable, 2'b11);
        chk("b_rst_rise", ifc_b.io_rise, 2'b00);
        chk("b_rst_fall", ifc_b.io_fall, 2'b00);
        chk("b_rst_count", ifc_b.io_evt_count, 0);
        rst_b = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            chk("b_q", ifc_b.io_q, 2'b11);
            chk("b_stable", ifc_b.io_q_stable, 2'b11);
            chk("b_rise", ifc_b.io_rise, 2'b00);
            chk("b_fall", ifc_b.io_fall, 2'b00);
            chk("b_count", ifc_b.io_evt_count, 0);
        end

        // Latency: io_q after 3 edges, stable + rise after 7, count after 8
        chk("a_rst_q", ifc_a.io_q, 2'b00);
        chk("a_rst_stable", ifc_a.io_q_stable, 2'b00);
        chk("a_rst_count", ifc_a.io_evt_count, 0);
        rst_a = 1'b1;
        ifc_a.io_d = 2'b01;
        for (int t = 1; t <= 8; t++) begin
            tick();
            chk("t1_q", ifc_a.io_q, (t >= 3) ? 2'b01 : 2'b00);
            chk("t1_stable", ifc_a.io_q_stable, (t >= 7) ? 2'b01 : 2'b00);
            chk("t1_rise", ifc_a.io_rise, (t == 7) ? 2'b01 : 2'b00);
            chk("t1_fall", ifc_a.io_fall, 2'b00);
            chk("t1_count", ifc_a.io_evt_count, (t >= 8) ? 1 : 0);
        end

        // 2-cycle glitch is discarded
        rst_a = 1'b0; ifc_a.io_d = 2'b00;
        tick();
        rst_a = 1'b1;
        qhi = 0;
        for (int t = 1; t <= 14; t++) begin
            ifc_a.io_d = (t <= 2) ? 2'b01 : 2'b00;
            tick();
            qhi += int'(ifc_a.io_q[0]);
            chk("t2_stable", ifc_a.io_q_stable, 2'b00);
            chk("t2_rise", ifc_a.io_rise, 2'b00);
            chk("t2_fall", ifc_a.io_fall, 2'b00);
        end
        chk("t2_qpulse_len", qhi, 2);
        chk("t2_count", ifc_a.io_evt_count, 0);

        // 4-cycle pulse survives; stable falls 4 cycles after io_q
        qhi = 0; shi = 0; nr = 0; nf = 0; t_qfall = 0; t_sfall = 0;
        prevq = 2'b00;
        for (int t = 1; t <= 16; t++) begin
            ifc_a.io_d = (t <= 4) ? 2'b01 : 2'b00;
            tick();
            qhi += int'(ifc_a.io_q[0]);
            shi += int'(ifc_a.io_q_stable[0]);
            nr  += int'(ifc_a.io_rise[0]);
            nf  += int'(ifc_a.io_fall[0]);
            if (qhi > 0 && !ifc_a.io_q[0] && t_qfall == 0) t_qfall = t;
            if (ifc_a.io_fall[0]) t_sfall = t;
        end
        chk("t2b_qpulse_len", qhi, 4);
        chk("t2b_stable_len", shi, 4);
        chk("t2b_rises", nr, 1);
        chk("t2b_falls", nf, 1);
        chk("t2b_fall_delay", t_sfall - t_qfall, 4);
        chk("t2b_count", ifc_a.io_evt_count, 2);

        // Saturating 2-bit counter, then clear beats a simultaneous rise
        rst_c = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            ifc_c.io_d = (k % 2 == 1) ? 2'b01 : 2'b00;
            for (int t = 1; t <= 10; t++) tick();
            chk("t4_count", ifc_c.io_evt_count, (k >= 3) ? 3 : k);
        end
        ifc_c.io_d = 2'b11;
        for (int t = 1; t <= 7; t++) tick();
        chk("t4_rise_seen", ifc_c.io_rise, 2'b10);
        ifc_c.io_clr_count = 1'b1;
        tick();
        ifc_c.io_clr_count = 1'b0;
        chk("t4_clr_count", ifc_c.io_evt_count, 0);
        ifc_c.io_d = 2'b01;
        for (int t = 1; t <= 8; t++) tick();
        chk("t4_after_clr", ifc_c.io_evt_count, 1);

        // Reset mid-filter with count=5 on instance A
        ifc_a.io_d = 2'b01; for (int t = 1; t <= 10; t++) tick();
        ifc_a.io_d = 2'b00; for (int t = 1; t <= 10; t++) tick();
        ifc_a.io_d = 2'b10; for (int t = 1; t <= 10; t++) tick();
        chk("t5_pre_count", ifc_a.io_evt_count, 5);
        chk("t5_pre_stable", ifc_a.io_q_stable, 2'b10);
        ifc_a.io_d = 2'b01;
        for (int t = 1; t <= 5; t++) tick();
        chk("t5_mid_q", ifc_a.io_q, 2'b01);
        chk("t5_mid_stable", ifc_a.io_q_stable, 2'b10);
        rst_a = 1'b0;
        tick();
        chk("t5_rst_q", ifc_a.io_q, 2'b00);
        chk("t5_rst_stable", ifc_a.io_q_stable, 2'b00);
        chk("t5_rst_count", ifc_a.io_evt_count, 0);
        chk("t5_rst_rise", ifc_a.io_rise, 2'b00);
        chk("t5_rst_fall", ifc_a.io_fall, 2'b00);
        rst_a = 1'b1; ifc_a.io_d = 2'b00;
        for (int t = 1; t <= 10; t++) begin
            tick();
            chk("t5_post_rise", ifc_a.io_rise, 2'b00);
            chk("t5_post_fall", ifc_a.io_fall, 2'b00);
            chk("t5_post_count", ifc_a.io_evt_count, 0);
        end

        // FILTER=0: stable follows io_q, edges track io_q directly
        rst_d = 1'b1;
        prevq = 2'b00; cnt_m = 0;
        for (int t = 1; t <= 200; t++) begin
            v = 2'($urandom_range(0, 3));
            ifc_d.io_d = v;
            ap.push_back(v);
            tick();
            if (t >= 3) chk("t6_q_latency", ifc_d.io_q, ap[t-3]);
            chk("t6_stable", ifc_d.io_q_stable, ifc_d.io_q);
            e_r = ifc_d.io_q & ~prevq;
            e_f = ~ifc_d.io_q & prevq;
            chk("t6_rise", ifc_d.io_rise, e_r);
            chk("t6_fall", ifc_d.io_fall, e_f);
            chk("t6_count", ifc_d.io_evt_count, cnt_m);
            if ((e_r | e_f) != 2'b00 && cnt_m != 255) cnt_m++;
            prevq = ifc_d.io_q;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
